// File: rtl/prescaled_counter.sv
// Up/down modulo counter advanced by an internal prescaler strobe, with load, enable and tick/tc strobes.
// Optional feature macro: PRESCALED_COUNTER_SATURATE_EN (hold at the limits instead of wrapping).
module prescaled_counter #(
  parameter int     WIDTH    = 4,
  parameter longint MODULO   = 16,
  parameter int     PRESCALE = 2097152,
  parameter int     PS_WIDTH = $clog2(PRESCALE) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             tc
);

  localparam logic [WIDTH-1:0]    MAX_CNT = WIDTH'(MODULO - 1);
  localparam logic [PS_WIDTH-1:0] PS_LAST = PS_WIDTH'(PRESCALE - 1);

  logic [PS_WIDTH-1:0] ps_q, ps_d;
  logic [WIDTH-1:0]    count_q, count_d;
  logic                tick_q, tick_d;
  logic                tc_q, tc_d;
  logic                step;
  logic [WIDTH-1:0]    load_clamped;

  // MODULO may equal 2^WIDTH, so the range check is done at 64 bits.
  always_comb begin
    load_clamped = load_val;
    if (64'(load_val) >= 64'(MODULO)) begin
      load_clamped = MAX_CNT;
    end
  end

  assign step = en && !load && (ps_q == PS_LAST);

  always_comb begin
    ps_d    = ps_q;
    count_d = count_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (load) begin
      ps_d    = '0;
      count_d = load_clamped;
    end else if (en) begin
      if (step) begin
        ps_d   = '0;
        tick_d = 1'b1;
`ifdef PRESCALED_COUNTER_SATURATE_EN
        if (up_dn) begin
          if (count_q != MAX_CNT) begin
            count_d = count_q + WIDTH'(1);
            tc_d    = (count_q == MAX_CNT - WIDTH'(1));
          end
        end else begin
          if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
            tc_d    = (count_q == WIDTH'(1));
          end
        end
`else
        if (up_dn) begin
          if (count_q == MAX_CNT) begin
            count_d = '0;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q + WIDTH'(1);
          end
        end else begin
          if (count_q == '0) begin
            count_d = MAX_CNT;
            tc_d    = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
`endif
      end else begin
        ps_d = ps_q + PS_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ps_q    <= '0;
      count_q <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      ps_q    <= ps_d;
      count_q <= count_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign count = count_q;
  assign tick  = tick_q;
  assign tc    = tc_q;

endmodule
